// File: rtl/loadable_updown_counter.sv
// -----------------------------------------------------------------------------
// loadable_updown_counter
//
// Registered up/down counter with a programmable terminal value. It supports
// synchronous clear, clamped load, a cascade carry/borrow chain and a sticky
// wrap flag. Several instances can be chained into multi-digit counters, for
// example decade counters: wire each stage's cout to the next stage's cin.
// All stages share en, up and clk.
//
// Parameters
//   WIDTH  counter width in bits (>= 1)
//   MAX    terminal (wrap) value, 1 <= MAX <= 2**WIDTH-1; modulus is MAX+1
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (q=0, wrap=0)
//   clr    in   1      synchronous clear, highest priority
//   ld     in   1      synchronous load of d (values above MAX clamp to MAX)
//   d      in   WIDTH  load value
//   en     in   1      local count enable
//   cin    in   1      cascade enable from the previous stage (tie 1 at stage 0)
//   up     in   1      direction: 1 = up, 0 = down
//   q      out  WIDTH  registered count, never above MAX
//   tc     out  1      terminal count: up ? q==MAX : q==0 (combinational)
//   cout   out  1      cascade carry/borrow: tc & en & cin (combinational)
//   wrap   out  1      sticky flag, set by any wrap, cleared by clr/ld/reset
// -----------------------------------------------------------------------------
module loadable_updown_counter #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             cin,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             cout,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // Operation selected for the coming edge, in priority order.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_CLEAR = 2'd1,
      OP_LOAD  = 2'd2,
      OP_COUNT = 2'd3
   } op_e;

   op_e              op;
   logic             step;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count_val;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   // ---------------------------------------------------------------------------
   // Terminal count and cascade carry
   // ---------------------------------------------------------------------------
   // Both outputs are combinational from q and the control inputs, so a chain of
   // N stages has an N-deep ripple through cout -> cin. This lets every stage
   // step on the same edge at which its predecessor wraps.
   assign tc   = up ? (q == MAX) : (q == ZERO);
   assign step = en & cin;
   assign cout = tc & step;

   // ---------------------------------------------------------------------------
   // Load clamping
   // ---------------------------------------------------------------------------
   // Clamping keeps q inside 0..MAX, so the count path only needs to detect
   // equality with MAX or zero. Out-of-range states never have to be handled.
   assign load_val = (d > MAX) ? MAX : d;

   // ---------------------------------------------------------------------------
   // Count step
   // ---------------------------------------------------------------------------
   // tc already reports the wrap condition for the current direction. At the
   // terminal value the counter jumps to the opposite end of the range.
   // Elsewhere it steps by one, and WIDTH-bit arithmetic cannot overflow there.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so that no path can leave it unassigned and infer a latch.
      count_val = q;
      if (up) begin
         count_val = tc ? ZERO : (q + ONE);
      end else begin
         count_val = tc ? MAX : (q - ONE);
      end
   end

   // ---------------------------------------------------------------------------
   // Operation select: clr > ld > count > hold
   // ---------------------------------------------------------------------------
   always_comb begin
      op = OP_HOLD;
      if (clr) begin
         op = OP_CLEAR;
      end else if (ld) begin
         op = OP_LOAD;
      end else if (step) begin
         op = OP_COUNT;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------------
   // wrap is sticky. It is cleared by clear or load and set by a counting edge
   // that passes through the terminal value. When a wrap and a clear fall on the
   // same edge, the clear wins because it has priority in op.
   always_comb begin
      q_next    = q;
      wrap_next = wrap;
      unique case (op)
         OP_CLEAR: begin
            q_next    = ZERO;
            wrap_next = 1'b0;
         end
         OP_LOAD: begin
            q_next    = load_val;
            wrap_next = 1'b0;
         end
         OP_COUNT: begin
            q_next    = count_val;
            wrap_next = wrap | tc;
         end
         default: begin
            q_next    = q;
            wrap_next = wrap;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // Reset is asynchronous. An edge that is pending when rst_n falls is lost,
   // and counting resumes on the first rising edge with rst_n high.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments. All registers then
      // update together at the edge, whatever order the blocks evaluate in.
      if (!rst_n) begin
         q    <= ZERO;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Invariant: the count never leaves 0..MAX once out of reset.
   // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
   q_in_range : assert property (@(posedge clk) disable iff (!rst_n) q <= MAX)
      else $error("q above MAX");
`endif

endmodule

// File: tb/tb_loadable_updown_counter.sv
// -----------------------------------------------------------------------------
// Testbench for loadable_updown_counter.
//
// The main instance is a decade counter (WIDTH=4, MAX=9). It runs directed
// scenarios and then randomized traffic, which is scored against an arithmetic
// model. A separate two-stage decade chain exercises cascading and the
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_loadable_updown_counter;

   localparam int WIDTH = 4;
   localparam int MAX_V = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr, ld, en, cin, up;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc, cout, wrap;

   // cascade chain
   logic             c_en, c_up;
   logic [WIDTH-1:0] c0_q, c1_q;
   logic             c0_tc, c1_tc, c0_cout, c1_cout, c0_wrap, c1_wrap;

   int checks = 0;
   int errors = 0;

   // reference model state
   int model_q;
   bit model_wrap;

   always #5 clk = ~clk;

   loadable_updown_counter #(.WIDTH(WIDTH), .MAX(4'd9)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d), .en(en),
      .cin(cin), .up(up), .q(q), .tc(tc), .cout(cout), .wrap(wrap)
   );

   loadable_updown_counter #(.WIDTH(WIDTH), .MAX(4'd9)) stage0 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(1'b0), .d(4'd0), .en(c_en),
      .cin(1'b1), .up(c_up), .q(c0_q), .tc(c0_tc), .cout(c0_cout), .wrap(c0_wrap)
   );

   loadable_updown_counter #(.WIDTH(WIDTH), .MAX(4'd9)) stage1 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(1'b0), .d(4'd0), .en(c_en),
      .cin(c0_cout), .up(c_up), .q(c1_q), .tc(c1_tc), .cout(c1_cout), .wrap(c1_wrap)
   );

   // One rising edge, then settle. Outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: modulo-(MAX+1) arithmetic with the priority rules.
   task automatic model_step(input bit m_clr, input bit m_ld, input int m_d,
                             input bit m_en, input bit m_cin, input bit m_up);
      if (m_clr) begin
         model_q = 0;
         model_wrap = 0;
      end else if (m_ld) begin
         model_q = (m_d > MAX_V) ? MAX_V : m_d;
         model_wrap = 0;
      end else if (m_en && m_cin) begin
         if (m_up) begin
            if (model_q == MAX_V) model_wrap = 1;
            model_q = (model_q + 1) % (MAX_V + 1);
         end else begin
            if (model_q == 0) model_wrap = 1;
            model_q = (model_q + MAX_V) % (MAX_V + 1);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr = 0; ld = 0; d = '0; en = 1; cin = 1; up = 0;
      c_en = 0; c_up = 1;
      #2;
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: q=%0d wrap=%b, required q=0 wrap=0", q, wrap);
      end
      checks++;
      if (tc !== 1'b1 || cout !== 1'b1) begin
         errors++;
         $display("FAIL reset_tc_down: tc=%b cout=%b, required tc=1 cout=1", tc, cout);
      end
      up = 1;
      #1;
      checks++;
      if (tc !== 1'b0 || cout !== 1'b0) begin
         errors++;
         $display("FAIL reset_tc_up: tc=%b cout=%b, required tc=0 cout=0", tc, cout);
      end
      // Hold reset across an edge, then release it away from the edge.
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_decade_up();
      en = 1; cin = 1; up = 1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (q !== 4'(i) || tc !== (i == 9) || wrap !== 1'b0) begin
            errors++;
            $display("FAIL decade_up[%0d]: q=%0d tc=%b wrap=%b, required q=%0d tc=%b wrap=0",
                     i, q, tc, wrap, i, (i == 9));
         end
         tick();
      end
      checks++;
      if (q !== 4'd0 || wrap !== 1'b1 || tc !== 1'b0) begin
         errors++;
         $display("FAIL decade_wrap: q=%0d wrap=%b tc=%b, required q=0 wrap=1 tc=0", q, wrap, tc);
      end
   endtask

   task automatic test_down_wrap_clamp();
      ld = 1; d = 4'd12;
      tick();
      ld = 0;
      checks++;
      if (q !== 4'd9 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL clamp_load: q=%0d wrap=%b, required q=9 wrap=0", q, wrap);
      end
      up = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (q !== 4'((k == 10) ? 9 : 9 - k) || wrap !== (k == 10)) begin
            errors++;
            $display("FAIL down_count[%0d]: q=%0d wrap=%b, required q=%0d wrap=%b",
                     k, q, wrap, (k == 10) ? 9 : 9 - k, (k == 10));
         end
      end
   endtask

   task automatic test_priority();
      // q=9, wrap=1 from the previous test. Count up to 3; wrap stays sticky.
      up = 1;
      repeat (4) tick();
      checks++;
      if (q !== 4'd3 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL priority_setup: q=%0d wrap=%b, required q=3 wrap=1", q, wrap);
      end
      clr = 1; ld = 1; en = 1; d = 4'd5;
      tick();
      clr = 0; ld = 0;
      checks++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL priority_clr: q=%0d wrap=%b, required q=0 wrap=0", q, wrap);
      end
   endtask

   task automatic test_ld_and_count();
      up = 0;
      tick();                  // 0 -> 9, sets wrap
      up = 1; ld = 1; en = 1; d = 4'd7;
      tick();
      ld = 0;
      checks++;
      if (q !== 4'd7 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL ld_over_count: q=%0d wrap=%b, required q=7 wrap=0", q, wrap);
      end
   endtask

   task automatic test_enable_direction();
      ld = 1; d = 4'd9;
      tick();
      ld = 0; en = 1; cin = 0; up = 1;
      #1;
      checks++;
      if (tc !== 1'b1 || cout !== 1'b0) begin
         errors++;
         $display("FAIL cout_gated: tc=%b cout=%b, required tc=1 cout=0", tc, cout);
      end
      cin = 1;
      #1;
      checks++;
      if (cout !== 1'b1) begin
         errors++;
         $display("FAIL cout_open: cout=%b, required 1", cout);
      end
      cin = 0; ld = 1; d = 4'd4;
      tick();
      ld = 0;
      repeat (3) tick();
      checks++;
      if (q !== 4'd4 || cout !== 1'b0) begin
         errors++;
         $display("FAIL cin_hold: q=%0d cout=%b, required q=4 cout=0", q, cout);
      end
      cin = 1;
      for (int i = 0; i < 3; i++) begin
         up = (i != 1);
         tick();
         checks++;
         if (q !== ((i == 1) ? 4'd4 : 4'd5)) begin
            errors++;
            $display("FAIL dir_flip[%0d]: q=%0d, required %0d", i, q, (i == 1) ? 4 : 5);
         end
      end
   endtask

   task automatic test_random();
      clr = 1;
      tick();
      clr = 0;
      model_q = 0;
      model_wrap = 0;
      for (int n = 0; n < 400; n++) begin
         clr = ($urandom_range(0, 19) == 0);
         ld  = ($urandom_range(0, 7) == 0);
         d   = 4'($urandom_range(0, 15));
         en  = ($urandom_range(0, 3) != 0);
         cin = ($urandom_range(0, 3) != 0);
         up  = $urandom_range(0, 1) == 1;
         #1;
         checks++;
         if (tc !== (up ? (model_q == MAX_V) : (model_q == 0)) ||
             cout !== ((up ? (model_q == MAX_V) : (model_q == 0)) && en && cin)) begin
            errors++;
            $display("FAIL rand_comb[%0d]: tc=%b cout=%b, model q=%0d up=%b en=%b cin=%b",
                     n, tc, cout, model_q, up, en, cin);
         end
         model_step(clr, ld, int'(d), en, cin, up);
         tick();
         checks++;
         if (q !== 4'(model_q) || wrap !== model_wrap) begin
            errors++;
            $display("FAIL rand_state[%0d]: q=%0d wrap=%b, required q=%0d wrap=%b",
                     n, q, wrap, model_q, model_wrap);
         end
      end
      clr = 0; ld = 0;
   endtask

   task automatic test_cascade();
      rst_n = 0;
      #1;
      rst_n = 1;
      c_en = 1; c_up = 1;
      for (int n = 1; n <= 100; n++) begin
         tick();
         checks++;
         if (c0_q !== 4'(n % 10) || c1_q !== 4'((n / 10) % 10)) begin
            errors++;
            $display("FAIL cascade[%0d]: low=%0d high=%0d, required low=%0d high=%0d",
                     n, c0_q, c1_q, n % 10, (n / 10) % 10);
         end
      end
      checks++;
      if (c1_wrap !== 1'b1 || c0_wrap !== 1'b1) begin
         errors++;
         $display("FAIL cascade_wrap: wrap0=%b wrap1=%b, required 1 1", c0_wrap, c1_wrap);
      end
      repeat (13) tick();       // low=3, high=1
      // Reset pulse mid-cycle, well away from both edges.
      #2;
      rst_n = 0;
      #1;
      checks++;
      if (c0_q !== 4'd0 || c1_q !== 4'd0 || c1_wrap !== 1'b0 || q !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: low=%0d high=%0d wrap1=%b q=%0d, required all 0",
                  c0_q, c1_q, c1_wrap, q);
      end
      #1;
      rst_n = 1;
      tick();
      checks++;
      if (c0_q !== 4'd1 || c1_q !== 4'd0) begin
         errors++;
         $display("FAIL after_reset: low=%0d high=%0d, required low=1 high=0", c0_q, c1_q);
      end
      c_en = 0;
   endtask

   initial begin
      test_reset();
      test_decade_up();
      test_down_wrap_clamp();
      test_priority();
      test_ld_and_count();
      test_enable_direction();
      test_random();
      test_cascade();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
